// File: rtl/messbauer_diff_discriminator_generator.sv
// -----------------------------------------------------------------------------
// messbauer_diff_discriminator_generator
//
// Emits differential-discriminator pulse pairs for the Messbauer test bench.
// Each channel gets a burst of IMPULSES_PER_CHANNEL impulses. A "selected"
// impulse drives only lower_threshold, so it falls inside the discriminator
// window. A "rejected" impulse nests an upper_threshold pulse inside the
// lower pulse. After a burst the block waits for the sequencer's channel
// strobe, then advances channel_index and starts the next burst.
//
// Ports
//   aclk             : clock
//   areset_n         : asynchronous active-low reset; every output goes to 0
//   start            : one-cycle request, accepted only while idle
//   stop             : one-cycle request; the current impulse and its pause
//                      complete, then the block goes idle
//   channel          : one-cycle channel-advance strobe
//   lower_threshold  : lower discriminator output
//   upper_threshold  : upper discriminator output
//   channel_index    : current channel number
//   busy             : high whenever the block is not idle
//   channel_done     : one-cycle pulse in the first cycle spent waiting for
//                      the channel strobe
//   frame_done       : one-cycle pulse when channel_index wraps to 0
//   overrun          : sticky flag; a channel strobe arrived while the block
//                      was not waiting for one (cleared only by start)
//   selected_count   : selected impulses emitted since start, saturating
// -----------------------------------------------------------------------------
module messbauer_diff_discriminator_generator #(
    parameter int LOWER_THRESHOLD_DURATION = 3,
    parameter int UPPER_THRESHOLD_DELAY    = 1,
    parameter int UPPER_THRESHOLD_DURATION = 1,
    parameter int IMPULSES_PAUSE           = 10,
    parameter int IMPULSES_PER_CHANNEL     = 16,
    parameter int IMPULSES_FOR_SELECTION   = 4,
    parameter int SELECTION_MODE           = 0,
    parameter int CHANNEL_COUNT            = 512,
    parameter int CHANNEL_WIDTH            = 9,
    parameter int COUNTER_WIDTH            = 16
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     channel,
    output logic                     lower_threshold,
    output logic                     upper_threshold,
    output logic [CHANNEL_WIDTH-1:0] channel_index,
    output logic                     busy,
    output logic                     channel_done,
    output logic                     frame_done,
    output logic                     overrun,
    output logic [COUNTER_WIDTH-1:0] selected_count
);

    // One counter times both the lower pulse and the pause.
    localparam int CNT_MAX = (LOWER_THRESHOLD_DURATION > IMPULSES_PAUSE) ?
                             LOWER_THRESHOLD_DURATION : IMPULSES_PAUSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (IMPULSES_PER_CHANNEL > 1) ? $clog2(IMPULSES_PER_CHANNEL) : 1;

    // The lower-pulse counter runs continuously from the lower rise, so the
    // phase boundaries are absolute offsets within the lower pulse.
    localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(UPPER_THRESHOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] UPPER_END = CNT_W'(UPPER_THRESHOLD_DELAY + UPPER_THRESHOLD_DURATION - 1);
    localparam logic [CNT_W-1:0] LOWER_END = CNT_W'(LOWER_THRESHOLD_DURATION - 1);
    localparam logic [CNT_W-1:0] PAUSE_END = CNT_W'(IMPULSES_PAUSE - 1);
    localparam logic [IDX_W-1:0] LAST_IMP  = IDX_W'(IMPULSES_PER_CHANNEL - 1);
    localparam logic [CHANNEL_WIDTH-1:0] LAST_CH = CHANNEL_WIDTH'(CHANNEL_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOWER_PRE,
        S_UPPER,
        S_LOWER_TAIL,
        S_PAUSE,
        S_WAIT_CHANNEL
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         imp_q, imp_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic [COUNTER_WIDTH-1:0] sel_cnt_q, sel_cnt_d;
    logic                     stop_pend_q, stop_pend_d;
    logic                     started_q, started_d;
    logic                     overrun_q, overrun_d;
    logic                     lower_q, lower_d;
    logic                     upper_q, upper_d;
    logic                     busy_q, busy_d;
    logic                     channel_done_q, channel_done_d;
    logic                     frame_done_q, frame_done_d;
    logic                     enter_lower;
    logic                     stop_now;

    // Selection rule for impulse index idx within the burst.
    function automatic logic is_selected(input logic [IDX_W-1:0] idx);
        int v;
        v = 32'(idx);
        if (SELECTION_MODE == 0) begin
            return v < IMPULSES_FOR_SELECTION;
        end
        return (idx[0] == 1'b0) && ((v >> 1) < IMPULSES_FOR_SELECTION);
    endfunction

    // Saturating increment for selected_count.
    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            imp_q          <= '0;
            chan_q         <= '0;
            sel_cnt_q      <= '0;
            stop_pend_q    <= 1'b0;
            started_q      <= 1'b0;
            overrun_q      <= 1'b0;
            lower_q        <= 1'b0;
            upper_q        <= 1'b0;
            busy_q         <= 1'b0;
            channel_done_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            imp_q          <= imp_d;
            chan_q         <= chan_d;
            sel_cnt_q      <= sel_cnt_d;
            stop_pend_q    <= stop_pend_d;
            started_q      <= started_d;
            overrun_q      <= overrun_d;
            lower_q        <= lower_d;
            upper_q        <= upper_d;
            busy_q         <= busy_d;
            channel_done_q <= channel_done_d;
            frame_done_q   <= frame_done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 1'b1;
        imp_d          = imp_q;
        chan_d         = chan_q;
        sel_cnt_d      = sel_cnt_q;
        stop_pend_d    = stop_pend_q;
        started_d      = started_q;
        overrun_d      = overrun_q;
        channel_done_d = 1'b0;
        frame_done_d   = 1'b0;
        enter_lower    = 1'b0;
        // A stop arriving on the very cycle a decision is taken still counts.
        stop_now       = stop_pend_q | stop;

        if ((state_q != S_IDLE) && stop) begin
            stop_pend_d = 1'b1;
        end

        // Before the first start there is nothing to overrun.
        if (channel && (state_q != S_WAIT_CHANNEL) &&
            ((state_q != S_IDLE) || started_q)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d     = S_LOWER_PRE;
                    enter_lower = 1'b1;
                    imp_d       = '0;
                    chan_d      = '0;
                    sel_cnt_d   = '0;
                    overrun_d   = 1'b0;
                    stop_pend_d = 1'b0;
                    started_d   = 1'b1;
                end
            end
            S_LOWER_PRE: begin
                if (cnt_q == PRE_END) begin
                    state_d = is_selected(imp_q) ? S_LOWER_TAIL : S_UPPER;
                end
            end
            S_UPPER: begin
                if (cnt_q == UPPER_END) begin
                    state_d = S_LOWER_TAIL;
                end
            end
            S_LOWER_TAIL: begin
                if (cnt_q == LOWER_END) begin
                    state_d = S_PAUSE;
                    cnt_d   = '0;
                end
            end
            S_PAUSE: begin
                if (cnt_q == PAUSE_END) begin
                    cnt_d = '0;
                    if (stop_now) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                    end else if (imp_q != LAST_IMP) begin
                        state_d     = S_LOWER_PRE;
                        imp_d       = imp_q + 1'b1;
                        enter_lower = 1'b1;
                    end else begin
                        state_d        = S_WAIT_CHANNEL;
                        channel_done_d = 1'b1;
                    end
                end
            end
            S_WAIT_CHANNEL: begin
                cnt_d = '0;
                // Stop outranks a simultaneous channel strobe.
                if (stop_now) begin
                    state_d     = S_IDLE;
                    stop_pend_d = 1'b0;
                end else if (channel) begin
                    state_d     = S_LOWER_PRE;
                    imp_d       = '0;
                    enter_lower = 1'b1;
                    if (chan_q == LAST_CH) begin
                        chan_d       = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        chan_d = chan_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Count on the lower rise of a selected impulse.
        if (enter_lower && is_selected(imp_d)) begin
            sel_cnt_d = sat_inc(sel_cnt_d);
        end

        // Outputs are registered copies of the next state's decode.
        lower_d = (state_d == S_LOWER_PRE) || (state_d == S_UPPER) || (state_d == S_LOWER_TAIL);
        upper_d = (state_d == S_UPPER);
        busy_d  = (state_d != S_IDLE);
    end

    assign lower_threshold = lower_q;
    assign upper_threshold = upper_q;
    assign channel_index   = chan_q;
    assign busy            = busy_q;
    assign channel_done    = channel_done_q;
    assign frame_done      = frame_done_q;
    assign overrun         = overrun_q;
    assign selected_count  = sel_cnt_q;

endmodule

// File: tb/tb_messbauer_diff_discriminator_generator.sv
// -----------------------------------------------------------------------------
// Bench for messbauer_diff_discriminator_generator.
// DUT A uses default parameters and is compared every cycle against a
// time-arithmetic model (burst start edge, burst end edge, channel state).
// DUT B uses CHANNEL_COUNT=4, SELECTION_MODE=1, N=3 and is checked with
// hand-computed literal expectations. Inputs change on falling edges;
// "edge e" below is the e-th rising edge of clk.
// -----------------------------------------------------------------------------
module tb_messbauer_diff_discriminator_generator;

    localparam int LD  = 3;
    localparam int DL  = 1;
    localparam int UD  = 1;
    localparam int PS  = 10;
    localparam int PER = 16;
    localparam int NS  = 4;
    localparam int CC  = 512;
    localparam int P   = LD + PS;
    localparam int INF = 1 << 30;

    logic clk;
    logic areset_n;
    logic a_start, a_stop, a_chan;
    logic a_lower, a_upper, a_busy, a_cdone, a_fdone, a_ovr;
    logic [8:0]  a_idx;
    logic [15:0] a_sel;
    logic b_start, b_stop, b_chan;
    logic b_lower, b_upper, b_busy, b_cdone, b_fdone, b_ovr;
    logic [1:0]  b_idx;
    logic [15:0] b_sel;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Model state for DUT A.
    int m_k = 0;          // edge at which the current burst's first lower rose
    int m_end = 0;        // edge at which the block (will) enter idle
    int m_frame = -1;     // edge at which frame_done is expected
    int m_idx = 0;
    int m_base = 0;       // selected impulses counted before the current burst
    bit m_ovr = 1'b0;
    bit m_started = 1'b0;

    messbauer_diff_discriminator_generator dut_a (
        .aclk(clk), .areset_n(areset_n),
        .start(a_start), .stop(a_stop), .channel(a_chan),
        .lower_threshold(a_lower), .upper_threshold(a_upper),
        .channel_index(a_idx), .busy(a_busy),
        .channel_done(a_cdone), .frame_done(a_fdone),
        .overrun(a_ovr), .selected_count(a_sel)
    );

    messbauer_diff_discriminator_generator #(
        .CHANNEL_COUNT(4), .CHANNEL_WIDTH(2),
        .SELECTION_MODE(1), .IMPULSES_FOR_SELECTION(3)
    ) dut_b (
        .aclk(clk), .areset_n(areset_n),
        .start(b_start), .stop(b_stop), .channel(b_chan),
        .lower_threshold(b_lower), .upper_threshold(b_upper),
        .channel_index(b_idx), .busy(b_busy),
        .channel_done(b_cdone), .frame_done(b_fdone),
        .overrun(b_ovr), .selected_count(b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit sel_a(input int j);
        return j < NS;
    endfunction

    function automatic int exp_sel(input int e);
        int n;
        n = m_base;
        for (int j = 0; j < PER; j++) begin
            if ((m_k + j * P <= e) && (m_k + j * P < m_end) && sel_a(j)) n++;
        end
        return n;
    endfunction

    // 0 = idle, 1 = inside the burst, 2 = waiting for the channel strobe.
    function automatic int phase(input int e);
        if ((e < m_k) || (e >= m_end)) return 0;
        if (e - m_k < PER * P) return 1;
        return 2;
    endfunction

    // Apply a request sampled at edge k to the model.
    task automatic model_step(input int k, input bit st, input bit sp, input bit ch);
        int ph;
        int j;
        ph = phase(k - 1);
        j  = (k - 1 - m_k) / P;
        case (ph)
            0: begin
                if (st) begin
                    m_k = k; m_end = INF; m_idx = 0; m_base = 0;
                    m_ovr = 1'b0; m_started = 1'b1;
                end else if (ch && m_started) begin
                    m_ovr = 1'b1;
                end
            end
            1: begin
                if (ch) m_ovr = 1'b1;
                if (sp && (m_k + (j + 1) * P < m_end)) m_end = m_k + (j + 1) * P;
            end
            default: begin
                if (sp) begin
                    m_end = k;
                end else if (ch) begin
                    m_base = exp_sel(k - 1);
                    if (m_idx == CC - 1) begin
                        m_idx = 0;
                        m_frame = k;
                    end else begin
                        m_idx++;
                    end
                    m_k = k;
                end
            end
        endcase
    endtask

    task automatic model_reset();
        m_k = 0; m_end = 0; m_frame = -1; m_idx = 0; m_base = 0;
        m_ovr = 1'b0; m_started = 1'b0;
    endtask

    task automatic compare_a();
        int e, off, r, j;
        bit busy_e, inb;
        e      = cyc;
        off    = e - m_k;
        busy_e = (e >= m_k) && (e < m_end);
        inb    = busy_e && (off < PER * P);
        r      = inb ? off % P : 0;
        j      = inb ? off / P : 0;
        chk("lower", a_lower, inb && (r < LD));
        chk("upper", a_upper, inb && !sel_a(j) && (r >= DL) && (r < DL + UD));
        chk("busy", a_busy, busy_e);
        chk("channel_done", a_cdone, busy_e && (off == PER * P));
        chk("frame_done", a_fdone, e == m_frame);
        chk("overrun", a_ovr, m_ovr);
        chk("channel_index", a_idx, m_idx);
        chk("selected_count", a_sel, exp_sel(e));
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        compare_a();
    end

    // Advance to the falling edge that follows rising edge e.
    task automatic goto_neg(input int e);
        checks++;
        if (cyc > e) begin
            failures++;
            $display("FAIL schedule: edge %0d already passed, now %0d", e, cyc);
        end
        while (cyc < e) @(negedge clk);
    endtask

    // Present a request so that it is sampled at edge at.
    task automatic drive(input bit to_b, input bit st, input bit sp, input bit ch, input int at);
        goto_neg(at - 1);
        if (to_b) begin
            b_start = st; b_stop = sp; b_chan = ch;
        end else begin
            a_start = st; a_stop = sp; a_chan = ch;
            model_step(at, st, sp, ch);
        end
        goto_neg(at);
        a_start = 0; a_stop = 0; a_chan = 0;
        b_start = 0; b_stop = 0; b_chan = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [15:0] b_rej;
    int kb;

    initial begin
        areset_n = 1'b0;
        a_start = 0; a_stop = 0; a_chan = 0;
        b_start = 0; b_stop = 0; b_chan = 0;
        b_rej = 16'b1111_1111_1110_1010;
        goto_neg(2);
        areset_n = 1'b1;

        // Reset state.
        goto_neg(3);
        chk("lit reset lower", a_lower, 0);
        chk("lit reset busy", a_busy, 0);
        chk("lit reset index", a_idx, 0);
        chk("lit reset b busy", b_busy, 0);

        // First burst from start at edge 5.
        drive(0, 1, 0, 0, 5);
        chk("lit first lower", a_lower, 1);
        chk("lit first sel", a_sel, 1);
        goto_neg(6);
        chk("lit imp0 no upper", a_upper, 0);
        goto_neg(8);
        chk("lit lower ends", a_lower, 0);
        goto_neg(45);
        chk("lit imp3 no upper", a_upper, 0);
        goto_neg(58);
        chk("lit imp4 upper", a_upper, 1);
        goto_neg(212);
        chk("lit cdone early", a_cdone, 0);
        goto_neg(213);
        chk("lit cdone", a_cdone, 1);
        chk("lit burst sel", a_sel, 4);

        // Channel advance, overrun mid-impulse, stop during upper of impulse 5.
        drive(0, 0, 0, 1, 220);
        chk("lit index 1", a_idx, 1);
        chk("lit lower after channel", a_lower, 1);
        drive(0, 0, 0, 1, 247);
        chk("lit overrun", a_ovr, 1);
        chk("lit index held", a_idx, 1);
        drive(0, 0, 1, 0, 287);
        goto_neg(297);
        chk("lit busy before stop", a_busy, 1);
        goto_neg(298);
        chk("lit busy after stop", a_busy, 0);
        goto_neg(300);
        chk("lit sel after 2nd burst", a_sel, 8);

        // Restart clears overrun; then stop+channel together while waiting.
        drive(0, 1, 0, 0, 310);
        chk("lit start clears overrun", a_ovr, 0);
        chk("lit restart index", a_idx, 0);
        goto_neg(518);
        chk("lit cdone 2", a_cdone, 1);
        drive(0, 0, 0, 1, 525);
        drive(0, 0, 1, 1, 740);
        chk("lit stop+chan busy", a_busy, 0);
        chk("lit stop+chan index", a_idx, 1);
        drive(0, 0, 0, 1, 750);
        chk("lit idle overrun", a_ovr, 1);

        // Asynchronous reset in the middle of impulse 1.
        drive(0, 1, 0, 0, 760);
        goto_neg(773);
        chk("lit imp1 lower", a_lower, 1);
        chk("lit imp1 sel", a_sel, 2);
        #2;
        areset_n = 1'b0;
        model_reset();
        #1;
        chk("lit async lower", a_lower, 0);
        chk("lit async busy", a_busy, 0);
        chk("lit async sel", a_sel, 0);
        goto_neg(776);
        areset_n = 1'b1;
        goto_neg(810);
        chk("lit no impulse after reset", a_lower, 0);
        chk("lit idle after reset", a_busy, 0);

        // DUT B: mode 1, three selected impulses (0, 2, 4), four channels.
        kb = 820;
        drive(1, 1, 0, 0, kb);
        for (int j = 0; j < 16; j++) begin
            goto_neg(kb + 13 * j + 1);
            chk("lit b lower", b_lower, 1);
            chk("lit b upper", b_upper, b_rej[j]);
        end
        goto_neg(kb + 208);
        chk("lit b cdone", b_cdone, 1);
        chk("lit b sel", b_sel, 3);
        for (int n = 1; n <= 4; n++) begin
            goto_neg(kb + 215 * n - 1);
            chk("lit b index before", b_idx, (n - 1) % 4);
            drive(1, 0, 0, 1, kb + 215 * n);
            chk("lit b index", b_idx, n % 4);
            chk("lit b frame", b_fdone, (n == 4) ? 1 : 0);
            chk("lit b lower", b_lower, 1);
        end
        goto_neg(kb + 215 * 4 + 1);
        chk("lit b frame pulse ends", b_fdone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
